// File: rtl/phase_meter.sv
// Recovers the DDS tuning word from an observed 8-bit truncated phase stream
// by summing unwrapped phase deltas over a window of 2^WIN_LOG2 samples.
module phase_meter #(
   parameter int WIDTH    = 14,
   parameter int WIN_LOG2 = 6
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic       cont,
   input  logic [7:0] phase,
   input  logic       phase_valid,
   output logic [7:0] phinc_est,
   output logic       est_valid,
   output logic       busy,
   output logic       ovf
);

   localparam int SW = 8 + WIN_LOG2;
   localparam int SH = WIDTH - 8 - WIN_LOG2;

   typedef enum logic [1:0] {IDLE, PRIME, ACC} state_t;

   state_t              state_q, state_d;
   logic [SW-1:0]       sum_q, sum_d;
   logic [WIN_LOG2-1:0] count_q, count_d;
   logic [7:0]          prev_q, prev_d;
   logic [7:0]          est_q, est_d;
   logic                ev_q, ev_d;
   logic                busy_q, busy_d;
   logic                ovf_q, ovf_d;

   logic [7:0]          delta;
   logic [SW-1:0]       total;
   logic [WIDTH-1:0]    scaled;

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      count_d = count_q;
      prev_d  = prev_q;
      est_d   = est_q;
      ev_d    = 1'b0;
      ovf_d   = ovf_q;
      // mod-256 subtraction unwraps the 0xFF->0x00 crossing for free
      delta   = phase - prev_q;
      total   = sum_q + SW'(delta);
      scaled  = WIDTH'(total) << SH;
      case (state_q)
         IDLE: begin
            if (start) state_d = PRIME;
         end
         PRIME: begin
            if (phase_valid) begin
               prev_d  = phase;
               state_d = ACC;
            end
         end
         ACC: begin
            if (phase_valid) begin
               prev_d  = phase;
               sum_d   = total;
               count_d = count_q + WIN_LOG2'(1);
               if (count_q == '1) begin
                  sum_d   = '0;
                  count_d = '0;
                  ev_d    = 1'b1;
                  if (|scaled[WIDTH-1:8]) begin
                     est_d = 8'hFF;
                     ovf_d = 1'b1;
                  end else begin
                     est_d = scaled[7:0];
                  end
                  if (!cont) state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         sum_q   <= '0;
         count_q <= '0;
         prev_q  <= '0;
         est_q   <= '0;
         ev_q    <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         prev_q  <= prev_d;
         est_q   <= est_d;
         ev_q    <= ev_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign phinc_est = est_q;
   assign est_valid = ev_q;
   assign busy      = busy_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_phase_meter.sv
// Bench for phase_meter: default instance against a sample-queue reference
// model every cycle, plus a WIN_LOG2=3 instance for quantization/saturation.
module tb_phase_meter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr, start, cont, pv;
   logic [7:0] phase;
   logic [7:0] phinc_est;
   logic       est_valid, busy, ovf;

   logic       clr1, start1, cont1, pv1;
   logic [7:0] phase1;
   logic [7:0] est1;
   logic       ev1, busy1, ovf1;

   int vectors = 0;
   int miscompares = 0;

   phase_meter u0 (
      .clk(clk), .clr(clr), .start(start), .cont(cont),
      .phase(phase), .phase_valid(pv),
      .phinc_est(phinc_est), .est_valid(est_valid),
      .busy(busy), .ovf(ovf)
   );

   phase_meter #(.WIDTH(14), .WIN_LOG2(3)) u1 (
      .clk(clk), .clr(clr1), .start(start1), .cont(cont1),
      .phase(phase1), .phase_valid(pv1),
      .phinc_est(est1), .est_valid(ev1),
      .busy(busy1), .ovf(ovf1)
   );

   // Reference model: collect accepted samples, evaluate window on the Nth delta.
   int         m_mode;
   logic [7:0] m_samp[$];
   logic [7:0] m_est;
   logic       m_ev, m_busy, m_ovf;

   always @(posedge clk) begin
      int adv;
      m_ev = 1'b0;
      if (clr) begin
         m_mode = 0;
         m_samp.delete();
         m_est = 8'd0;
         m_ovf = 1'b0;
      end else if (m_mode == 0) begin
         if (start) m_mode = 1;
      end else if (pv) begin
         m_samp.push_back(phase);
         m_mode = 2;
         if (m_samp.size() == 65) begin
            adv = 0;
            for (int i = 1; i < 65; i++)
               adv += (int'(m_samp[i]) - int'(m_samp[i-1]) + 256) % 256;
            if (adv > 255) begin
               m_est = 8'hFF;
               m_ovf = 1'b1;
            end else begin
               m_est = 8'(adv);
            end
            m_ev = 1'b1;
            m_samp = m_samp[64:64];
            if (!cont) begin
               m_mode = 0;
               m_samp.delete();
            end
         end
      end
      m_busy = (m_mode != 0);
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      chk("m_est", 32'(phinc_est), 32'(m_est));
      chk("m_ev", 32'(est_valid), 32'(m_ev));
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_ovf", 32'(ovf), 32'(m_ovf));
   endtask

   // Drive an accumulator source into u0 and check each window's estimate.
   task automatic measure(int phinc, int init, int nwin, int gap,
                          int poke, logic [7:0] exp);
      logic [13:0] acc;
      int wins, budget, it;
      acc    = 14'(init);
      wins   = 0;
      budget = 300 * nwin;
      it     = 0;
      cont   = (nwin > 1);
      start  = 1'b1;
      pv     = 1'b0;
      tick();
      start  = 1'b0;
      while (wins < nwin && budget > 0) begin
         pv    = (gap == 0) || ($urandom_range(99) >= 32'(gap));
         phase = acc[13:6];
         start = (it == poke);
         tick();
         start = 1'b0;
         if (pv) acc = acc + 14'(phinc);
         if (est_valid) begin
            chk("win_est", 32'(phinc_est), 32'(exp));
            chk("win_ovf", 32'(ovf), 32'd0);
            wins++;
            if (wins == nwin - 1) cont = 1'b0;
         end
         budget--;
         it++;
      end
      if (budget == 0) begin
         miscompares++;
         $display("FAIL timeout: got %0d windows expected %0d", wins, nwin);
      end
      pv = 1'b0;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   typedef struct {
      int         phinc;
      int         init;
      int         nwin;
      int         gap;
      int         poke;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [13:0] acc1;
      int evs, r;

      tbl[0] = '{64, 0, 1, 0, -1, 8'd64};
      tbl[1] = '{100, 'h2A7F, 3, 0, -1, 8'd100};
      tbl[2] = '{255, 'h3F00, 3, 0, -1, 8'd255};
      tbl[3] = '{37, 'h1234, 1, 50, -1, 8'd37};
      tbl[4] = '{1, 'h3FFF, 1, 0, -1, 8'd1};
      tbl[5] = '{128, 'h0040, 1, 0, 20, 8'd128};

      clr = 1'b1; start = 1'b0; cont = 1'b0; pv = 1'b0; phase = 8'd0;
      clr1 = 1'b1; start1 = 1'b0; cont1 = 1'b0; pv1 = 1'b0; phase1 = 8'd0;
      tick();
      tick();
      chk("rst_est", 32'(phinc_est), 32'd0);
      chk("rst_ev", 32'(est_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      clr = 1'b0;
      clr1 = 1'b0;

      // Samples while idle must be ignored.
      pv = 1'b1;
      for (int i = 0; i < 10; i++) begin
         phase = 8'(i * 7);
         tick();
      end
      chk("idle_ign", 32'(busy), 32'd0);

      for (int i = 0; i < 6; i++)
         measure(tbl[i].phinc, tbl[i].init, tbl[i].nwin,
                 tbl[i].gap, tbl[i].poke, tbl[i].exp);

      for (int i = 0; i < 6; i++) begin
         r = int'($urandom_range(255, 1));
         measure(r, int'($urandom_range(16383)), 1,
                 (i % 2 == 0) ? 0 : 40, -1, 8'(r));
      end

      // Abort at sample 30 of a window.
      start = 1'b1; pv = 1'b0;
      tick();
      start = 1'b0;
      pv = 1'b1;
      for (int i = 0; i < 31; i++) begin
         phase = 8'(i * 3);
         tick();
      end
      chk("abort_busy_pre", 32'(busy), 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("abort_est", 32'(phinc_est), 32'd0);
      chk("abort_ev", 32'(est_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      evs = 0;
      for (int i = 0; i < 80; i++) begin
         phase = 8'(i * 3);
         tick();
         if (est_valid) evs++;
      end
      chk("abort_no_ev", 32'(evs), 32'd0);
      measure(77, 'h0123, 1, 0, -1, 8'd77);

      // WIN_LOG2=3 instance: quantized window, then a saturating one.
      chk("u1_rst", 32'({est1, ev1, busy1, ovf1}), 32'd0);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      acc1 = 14'h0155;
      pv1 = 1'b1;
      for (int i = 0; i < 9; i++) begin
         phase1 = acc1[13:6];
         tick();
         acc1 = acc1 + 14'd200;
      end
      pv1 = 1'b0;
      chk("u1_ev", 32'(ev1), 32'd1);
      chk("u1_quant", 32'((est1 == 8'd192 || est1 == 8'd200) && est1[2:0] == 3'd0), 32'd1);
      chk("u1_ovf0", 32'(ovf1), 32'd0);
      tick();
      chk("u1_busy", 32'(busy1), 32'd0);

      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      pv1 = 1'b1;
      for (int i = 0; i < 9; i++) begin
         phase1 = 8'(i * 128);
         tick();
      end
      pv1 = 1'b0;
      chk("u1_sat_est", 32'(est1), 32'd255);
      chk("u1_sat_ovf", 32'(ovf1), 32'd1);

      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      pv1 = 1'b1;
      for (int i = 0; i < 9; i++) begin
         phase1 = acc1[13:6];
         tick();
         acc1 = acc1 + 14'd200;
      end
      pv1 = 1'b0;
      chk("u1_post_ev", 32'(ev1), 32'd1);
      chk("u1_post_quant", 32'((est1 == 8'd192 || est1 == 8'd200) && est1[2:0] == 3'd0), 32'd1);
      chk("u1_sticky", 32'(ovf1), 32'd1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
